// File: rtl/i2c_target.sv
// i2c_target: I2C target that ACKs its 7-bit address, receives write bytes and serves read bytes
module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       core_clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_p, r_sda_p;
  logic [2:0]             r_cnt;
  logic [7:0]             r_shift;
  logic                   r_full, r_rw, r_nack, r_sda;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid, r_tx_req;
  logic                   w_scl_s, w_sda_s, w_rise, w_fall, w_start, w_stop;
  logic [2:0]             w_cnt_dec;
  assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s   = r_sda_sync[SYNC_STAGES-1];
  assign w_rise    = w_scl_s & ~r_scl_p;
  assign w_fall    = ~w_scl_s & r_scl_p;
  assign w_start   = w_scl_s & r_sda_p & ~w_sda_s;
  assign w_stop    = w_scl_s & ~r_sda_p & w_sda_s;
  assign w_cnt_dec = (r_cnt == 3'd0) ? 3'd0 : r_cnt - 3'd1;
  assign sda_out   = r_sda;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_req    = r_tx_req;
  assign busy      = (r_state != IDLE);
  // Synchronize the pins and keep their previous levels for edge detection (idle bus reads high)
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_p    <= 1'b1;
      r_sda_p    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_p    <= w_scl_s;
      r_sda_p    <= w_sda_s;
    end
  end
  // Protocol FSM: sample on SCL rise, drive SDA on SCL fall; START/STOP override everything
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd7;
      r_shift    <= 8'h00;
      r_full     <= 1'b0;
      r_rw       <= 1'b0;
      r_nack     <= 1'b0;
      r_sda      <= 1'b1;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (w_start) begin
        r_state <= ADDR;
        r_cnt   <= 3'd7;
        r_full  <= 1'b0;
        r_sda   <= 1'b1;
      end else if (w_stop) begin
        r_state <= IDLE;
        r_full  <= 1'b0;
        r_sda   <= 1'b1;
      end else begin
        case (r_state)
          ADDR, RX_DATA: begin
            if (w_rise) begin
              r_shift <= {r_shift[6:0], w_sda_s};
              r_cnt   <= w_cnt_dec;
              r_full  <= (r_cnt == 3'd0);
            end else if (w_fall && r_full) begin
              r_full <= 1'b0;
              r_cnt  <= 3'd7;
              if (r_state == RX_DATA) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_sda      <= 1'b0;
                r_state    <= RX_ACK;
              end else if (r_shift[7:1] == SLAVE_ADDR) begin
                r_sda   <= 1'b0;
                r_rw    <= r_shift[0];
                r_state <= ADDR_ACK;
              end else begin
                r_state <= WAIT;
              end
            end
          end
          ADDR_ACK: begin
            if (w_rise) begin
              r_tx_req <= r_rw;
            end else if (w_fall) begin
              r_cnt   <= 3'd7;
              r_shift <= r_rw ? tx_data : r_shift;
              r_sda   <= r_rw ? tx_data[7] : 1'b1;
              r_state <= r_rw ? TX_DATA : RX_DATA;
            end
          end
          RX_ACK: begin
            if (w_fall) begin
              r_sda   <= 1'b1;
              r_cnt   <= 3'd7;
              r_state <= RX_DATA;
            end
          end
          TX_DATA: begin
            if (w_rise) begin
              r_cnt  <= w_cnt_dec;
              r_full <= (r_cnt == 3'd0);
            end else if (w_fall && r_full) begin
              r_full  <= 1'b0;
              r_sda   <= 1'b1;
              r_state <= TX_ACK;
            end else if (w_fall) begin
              r_shift <= {r_shift[6:0], 1'b0};
              r_sda   <= r_shift[6];
            end
          end
          TX_ACK: begin
            if (w_rise) begin
              r_nack   <= w_sda_s;
              r_tx_req <= ~w_sda_s;
            end else if (w_fall && r_nack) begin
              r_state <= WAIT;
            end else if (w_fall) begin
              r_shift <= tx_data;
              r_sda   <= tx_data[7];
              r_cnt   <= 3'd7;
              r_state <= TX_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder; the peer of the team's I2C master controller on the same SCL/SDA pair.
- Oversamples SCL/SDA on the core clock and detects START/STOP.
- Matches its 7-bit address and ACKs it.
- Receives write bytes into a byte-wide output with a valid pulse.
- Serves read bytes from an upstream source through a request/data handshake.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit target address compared against address-byte bits [7:1].
- SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in before edge detection (minimum 2).

Ports:
- core_clk  in  1  system clock; must be at least 8x the SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_in  in  1  SCL pin level (asynchronous).
- sda_in  in  1  SDA pin level (asynchronous).
- sda_out  out  1  0 = pull SDA low, 1 = release (open-drain).
- rx_data  out  8  last byte received in a write transfer.
- rx_valid  out  1  one-cycle pulse: rx_data holds a new byte.
- tx_req  out  1  one-cycle pulse: upstream must present the next read byte.
- tx_data  in  8  read byte; latched at the SCL fall that starts its bit 7.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset values: sda_out=1, rx_data=0, rx_valid=0, tx_req=0, busy=0, state=IDLE, bit counter=7. Reset mid-transfer releases SDA immediately.
- scl_s/sda_s are the synchronized pin levels; their previous-cycle values are also kept.
- Edge events (one core_clk each):
  - scl_rise / scl_fall on scl_s.
  - START = sda_s falls while scl_s is high.
  - STOP = sda_s rises while scl_s is high.
- START/STOP take priority over scl edges in the same cycle.
- START from any state (including repeated START): go to ADDR, counter=7, sda_out=1.
- STOP from any state: go to IDLE, sda_out=1.
- States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT.
  - WAIT = not addressed or master NACK; sda_out=1, leave only on START or STOP.
- Bit sampling and SDA changes:
  - Bits are sampled on scl_rise, MSB first.
  - sda_out changes only on scl_fall, except START/STOP/reset release.
- ADDR:
  - Shift sda_s on 8 scl_rise events.
  - At the following scl_fall: if shift[7:1]==SLAVE_ADDR, set sda_out=0 and go to ADDR_ACK with rw=shift[0] stored; otherwise go to WAIT.
  - General call (address 0) is not acknowledged.
- ADDR_ACK:
  - Hold sda_out=0.
  - If rw=1, pulse tx_req on the scl_rise of the ACK bit.
  - At scl_fall, rw=0: sda_out=1, go to RX_DATA.
  - At scl_fall, rw=1: latch tx_data into the shift register, drive bit 7, go to TX_DATA.
- RX_DATA:
  - 8 scl_rise samples.
  - At the scl_fall after the 8th: rx_data<=shift, rx_valid=1 for that cycle, sda_out=0 (ACK), go to RX_ACK.
  - Every received byte is ACKed; no NACK/backpressure.
- RX_ACK: at scl_fall, sda_out=1, counter=7, go to RX_DATA.
- TX_DATA:
  - On each scl_fall, drive the next bit.
  - At the scl_fall after bit 0 has been clocked: sda_out=1, go to TX_ACK.
- TX_ACK:
  - Sample sda_s at scl_rise.
  - If 0 (ACK): pulse tx_req; at scl_fall, latch tx_data, drive bit 7, go to TX_DATA.
  - If 1 (NACK): at scl_fall go to WAIT; no tx_req.
- Counter: 3-bit, decrements per sampled bit, reloads 7 at each byte boundary; never wraps into an extra bit.
- Upstream timing: tx_data must be stable from tx_req until the next scl_fall (at least half an SCL period).
- Pin-to-detection latency: SYNC_STAGES+1 core_clk.

Test Plan:
- Write: master sends START, 0xA0 (addr 0x50, W), 0x3C, 0xC3, STOP -> ACK low on all three ACK bits; rx_valid pulses twice with rx_data=0x3C then 0xC3; busy drops after STOP; sda_out=1.
- Address mismatch: START, 0xA2, 0x55, STOP -> sda_out stays 1 throughout, rx_valid never pulses, state WAIT then IDLE.
- Read: START, 0xA1, tx_data=0x96 then 0x5A, master ACKs byte 1 and NACKs byte 2 -> SDA bits 10010110 then 01011010; tx_req pulses exactly twice; SDA released after NACK.
- Repeated START: START, 0xA0, 0x11, Sr, 0xA1, master NACK, STOP -> rx_data=0x11 with one rx_valid; read phase serves tx_data; no STOP required between.
- STOP mid-byte: START, 0xA0, 4 data bits, STOP -> rx_valid never pulses; IDLE with sda_out=1; next full transfer works.
- Reset mid-ACK: assert rst_n=0 while sda_out=0 in ADDR_ACK -> sda_out=1 asynchronously; all outputs at reset values.
